// File: rtl/logic_op_sequencer.sv
// Self-test front end for the 4-function logic unit: walks 16 (select, operand) vectors in Gray
// order and captures the unit's result per step. Optional golden compare under LOGIC_SEQ_CHECK_EN.
module logic_op_sequencer #(
  parameter int unsigned STEP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        hold,
  input  logic        s_in,
  output logic        x,
  output logic        y,
  output logic        selec1,
  output logic        selec2,
  output logic        valid,
  output logic        busy,
  output logic        done,
  output logic [3:0]  index,
  output logic [15:0] result
`ifdef LOGIC_SEQ_CHECK_EN
  ,
  output logic [4:0]  mismatch_cnt
`endif
);

  localparam int unsigned StepW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [StepW-1:0] StepLast = StepW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [StepW-1:0] step_q, step_d;
  logic [3:0]       index_q, index_d;
  logic [15:0]      result_q, result_d;
  logic [3:0]       vec_q, vec_d;  // {selec1, selec2, x, y}
  logic             accept;

  function automatic logic [1:0] gray2(input logic [1:0] b);
    return {b[1], b[1] ^ b[0]};
  endfunction

  assign accept = start && ((state_q == StIdle) || (state_q == StDone));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (valid && (index_q == 4'd15)) state_d = StDone;
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy  = (state_q == StRun);
    done  = (state_q == StDone);
    valid = busy && !hold && (step_q == StepLast);
  end

  // Datapath next state; the vector follows the index being entered so it is registered
  always_comb begin
    step_d   = step_q;
    index_d  = index_q;
    result_d = result_q;
    if (accept) begin
      step_d   = '0;
      index_d  = '0;
      result_d = '0;
    end else if (busy && !hold) begin
      if (valid) begin
        result_d[index_q] = s_in;
        step_d            = '0;
        if (index_q != 4'd15) index_d = index_q + 4'd1;
      end else begin
        step_d = step_q + 1'b1;
      end
    end
    vec_d = (state_d == StRun) ? {gray2(index_d[3:2]), gray2(index_d[1:0])} : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q   <= '0;
      index_q  <= '0;
      result_q <= '0;
      vec_q    <= '0;
    end else begin
      step_q   <= step_d;
      index_q  <= index_d;
      result_q <= result_d;
      vec_q    <= vec_d;
    end
  end

  assign {selec1, selec2, x, y} = vec_q;
  assign index                  = index_q;
  assign result                 = result_q;

`ifdef LOGIC_SEQ_CHECK_EN
  localparam logic [15:0] Golden = 16'hA51E;

  logic [4:0] mis_q, mis_d;

  always_comb begin
    mis_d = mis_q;
    if (accept) begin
      mis_d = '0;
    end else if (valid && (s_in != Golden[index_q]) && (mis_q != 5'd31)) begin
      mis_d = mis_q + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q <= '0;
    end else begin
      mis_q <= mis_d;
    end
  end

  assign mismatch_cnt = mis_q;
`endif

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Directed bench for logic_op_sequencer: vector table checked per step on a STEP_CYCLES=1 instance,
// hold/reset/zero-result sequences, and latency/restart checks on a STEP_CYCLES=3 instance.
module tb_logic_op_sequencer;

  typedef struct packed {
    logic s1;
    logic s2;
    logic x;
    logic y;
    logic s;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance 1: STEP_CYCLES = 1
  logic start1 = 1'b0, hold1 = 1'b0, force_zero = 1'b0;
  logic s_in1, x1, y1, sa1, sb1, valid1, busy1, done1;
  logic [3:0]  index1;
  logic [15:0] result1;
  // Instance 3: STEP_CYCLES = 3
  logic start3 = 1'b0, hold3 = 1'b0;
  logic s_in3, x3, y3, sa3, sb3, valid3, busy3, done3;
  logic [3:0]  index3;
  logic [15:0] result3;
`ifdef LOGIC_SEQ_CHECK_EN
  logic [4:0] mis1, mis3;
`endif

  // Logic unit: 00 OR, 01 NOR, 11 XNOR, 10 XOR
  assign s_in1 = force_zero ? 1'b0 : ((sa1 ? (x1 ^ y1) : (x1 | y1)) ^ sb1);
  assign s_in3 = (sa3 ? (x3 ^ y3) : (x3 | y3)) ^ sb3;

  logic_op_sequencer #(.STEP_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .hold(hold1), .s_in(s_in1),
    .x(x1), .y(y1), .selec1(sa1), .selec2(sb1), .valid(valid1), .busy(busy1),
    .done(done1), .index(index1), .result(result1)
`ifdef LOGIC_SEQ_CHECK_EN
    , .mismatch_cnt(mis1)
`endif
  );

  logic_op_sequencer #(.STEP_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .hold(hold3), .s_in(s_in3),
    .x(x3), .y(y3), .selec1(sa3), .selec2(sb3), .valid(valid3), .busy(busy3),
    .done(done3), .index(index3), .result(result3)
`ifdef LOGIC_SEQ_CHECK_EN
    , .mismatch_cnt(mis3)
`endif
  );

  int   errors = 0;
  int   checks = 0;
  vec_t tab [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_vec(input int k);
    return {tab[k].s1, tab[k].s2, tab[k].x, tab[k].y};
  endfunction

  // One walk on instance 1; optional hold window, mid-run reset and forced-zero result
  task automatic walk1(input int hold_at, input int hold_len, input int rst_at, input logic zero_s);
    logic [15:0] exp_res;
    for (int k = 0; k < 16; k++) exp_res[k] = zero_s ? 1'b0 : tab[k].s;
    force_zero = zero_s;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy1, 0);
        check("rst_index", index1, 0);
        check("rst_result", result1, 0);
        check("rst_vec", {sa1, sb1, x1, y1}, 0);
        check("rst_valid", valid1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        force_zero = 1'b0;
        return;
      end
      if (k == hold_at) begin
        hold1 = 1'b1;
        for (int h = 0; h < hold_len; h++) begin
          #1;
          check("hold_valid", valid1, 0);
          check("hold_index", index1, k);
          check("hold_vec", {sa1, sb1, x1, y1}, exp_vec(k));
          @(negedge clk);
        end
        hold1 = 1'b0;
      end
      #1;
      check("run_busy", busy1, 1);
      check("run_done", done1, 0);
      check("run_valid", valid1, 1);
      check("run_index", index1, k);
      check("run_vec", {sa1, sb1, x1, y1}, exp_vec(k));
      @(negedge clk);
    end
    #1;
    check("done_pulse", done1, 1);
    check("done_busy", busy1, 0);
    check("done_vec", {sa1, sb1, x1, y1}, 0);
    check("done_result", result1, exp_res);
`ifdef LOGIC_SEQ_CHECK_EN
    check("done_mismatch", mis1, zero_s ? 8 : 0);
`endif
    @(negedge clk);
    #1;
    check("idle_done_low", done1, 0);
    check("idle_result_held", result1, exp_res);
    force_zero = 1'b0;
    @(negedge clk);
  endtask

  // Counts cycles from the first vector to done on instance 3; start pulsed mid-run
  task automatic walk3(input int restart_at, output int n, output int vcnt);
    n    = 0;
    vcnt = 0;
    while (done3 !== 1'b1 && n < 200) begin
      start3 = (n == restart_at);
      if (valid3 === 1'b1) vcnt++;
      @(negedge clk);
      n++;
    end
    start3 = 1'b0;
  endtask

  initial begin
    int n, vcnt;
    tab[0]  = 5'b00000; tab[1]  = 5'b00011; tab[2]  = 5'b00111; tab[3]  = 5'b00101;
    tab[4]  = 5'b01001; tab[5]  = 5'b01010; tab[6]  = 5'b01110; tab[7]  = 5'b01100;
    tab[8]  = 5'b11001; tab[9]  = 5'b11010; tab[10] = 5'b11111; tab[11] = 5'b11100;
    tab[12] = 5'b10000; tab[13] = 5'b10011; tab[14] = 5'b10110; tab[15] = 5'b10101;

    repeat (2) @(negedge clk);
    check("reset_busy", busy1, 0);
    check("reset_done", done1, 0);
    check("reset_valid", valid1, 0);
    check("reset_index", index1, 0);
    check("reset_result", result1, 0);
    check("reset_vec", {sa1, sb1, x1, y1}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    walk1(-1, 0, -1, 1'b0);
    check("golden_result", result1, 16'hA51E);
    walk1(7, 3, -1, 1'b0);
    walk1(-1, 0, 9, 1'b0);
    walk1(-1, 0, -1, 1'b0);
    walk1(-1, 0, -1, 1'b1);
    check("zero_result", result1, 16'h0000);

    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    #1;
    check("s3_busy", busy3, 1);
    check("s3_index", index3, 0);
    walk3(10, n, vcnt);
    check("s3_latency", n, 48);
    check("s3_valid_count", vcnt, 16);
    check("s3_done", done3, 1);
    check("s3_result", result3, 16'hA51E);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    #1;
    check("s3_restart_busy", busy3, 1);
    check("s3_restart_done", done3, 0);
    check("s3_restart_index", index3, 0);
    check("s3_restart_cleared", result3, 0);
    walk3(-1, n, vcnt);
    check("s3_latency2", n, 48);
    check("s3_result2", result3, 16'hA51E);
`ifdef LOGIC_SEQ_CHECK_EN
    check("s3_mismatch", mis3, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
